keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner with debounce; the upstream stage of the calculator datapath.
- Drives columns one at a time, reads rows, and debounces both press and release.
- Emits one 4-bit key code plus a single-cycle flag strobe per physical press.
- The code/strobe pair feeds the compute stage directly: 0-9 digits, 10-13 operators, 14 '=', 15 clear.

Parameters:
- SCAN_DIV, 50000, clk cycles per scan tick; 1 ms at 50 MHz. Minimum 2.
- DEBOUNCE_CNT, 20, consecutive stable ticks needed to accept a press or a release. Minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- row_in  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col_out  output  4  column drive, active-low, one-hot-low.
- data_out  output  4  code of last accepted key; holds until the next accepted press.
- flag  output  1  one-clk pulse marking a new valid data_out.

Behaviour:
- Reset values: col_out=4'b1110, data_out=0, flag=0, state=SCAN, all counters=0, row synchronizer=4'hF.
- Reset mid-operation aborts any debounce or press in progress. A key still held after reset is re-detected as a new press after full debounce.
- Row sync: row_in passes through a 2-flop synchronizer; all decisions use the synchronized value rows_s.
- Tick: a free-running counter runs 0..SCAN_DIV-1. tick=1 for the single cycle where the counter equals SCAN_DIV-1; the counter then wraps to 0.
- All state/column changes happen only on tick cycles, except the flag clear.
- Key map, index by (row r, col c) with col c driven low:
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 15, 0, 14, 13
- FSM states:
  - SCAN, on tick:
    - rows_s has exactly one 0 bit: capture row index and current column, cnt<=0, go to DEBOUNCE, col_out unchanged.
    - rows_s==4'hF or two or more bits low (ghost/multi-key): rotate col_out 1110->1101->1011->0111->1110, stay in SCAN.
  - DEBOUNCE, column held, on tick:
    - rows_s equals the captured pattern and cnt==DEBOUNCE_CNT-1: data_out<=mapped code, flag<=1, go to PRESSED.
    - rows_s equals the captured pattern otherwise: cnt++.
    - any mismatch: return to SCAN and rotate the column. No flag.
  - PRESSED, column held, on tick:
    - rows_s==4'hF: cnt<=0, go to RELEASE.
    - otherwise stay; holding the key never repeats.
  - RELEASE, column held, on tick:
    - rows_s==4'hF and cnt==DEBOUNCE_CNT-1: go to SCAN, col_out unchanged.
    - rows_s==4'hF otherwise: cnt++.
    - any row low: cnt<=0, stay in RELEASE (bounce).
- flag:
  - High exactly one clk cycle, the cycle after the accepting tick.
  - Cleared on the next clk regardless of tick.
  - Never two flags without an intervening accepted release.
- Latency from row_in settling low while its column is driven: 2 sync cycles + up to 1 tick period + DEBOUNCE_CNT ticks.
- A second key pressed while one is held is ignored. The first key must be released and debounced first.
- cnt width: clog2(DEBOUNCE_CNT)+1. Tick counter width: clog2(SCAN_DIV).

Test Plan:
Bench uses SCAN_DIV=4 and DEBOUNCE_CNT=3. The key model pulls row r low when col c is low and key (r,c) is held.
- Reset check: assert rst mid-count, then release -> col_out=1110, data_out=0, flag=0. First tick rotates col_out to 1101.
- Clean press of key (r1,c2), held 40 cycles, then released -> exactly one flag pulse with data_out=6; data_out stays 6 after release.
- Bouncy press: toggle (r0,c0) low/high across 2 ticks, then hold -> no flag during the bounce; one flag with data_out=1 after 3 stable ticks.
- Hold (r3,c2) for 200 cycles -> single flag, data_out=14; no repeat. Release bounce of 1 tick then stable high -> return to SCAN only after 3 clean ticks.
- Two keys held in the same column, (r0,c3) and (r1,c3) -> no flag while both are held. Release (r1,c3) -> one flag, data_out=10.
- Sequence 1, 2, 10, 3, 14 with a full release between each -> five flags, data_out 1, 2, 10, 3, 14 in order.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Emits a 4-bit key code and a one-cycle flag per accepted press.
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] data_out,
    output logic       flag
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t           state, state_n;
    logic [3:0]       rows_m, rows_s;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       cap_row, cap_row_n;
    logic [1:0]       cap_col, cap_col_n;
    logic [3:0]       col_n, data_n;
    logic             flag_n;
    logic             tick;
    logic             one_low;
    logic [1:0]       row_idx, col_idx;
    logic [3:0]       col_rot;
    logic [3:0]       cap_pattern;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
            4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
            4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
            4'hC: code = 4'd15;  4'hD: code = 4'd0;   4'hE: code = 4'd14;  default: code = 4'd13;
        endcase
        return code;
    endfunction

    // rows are asynchronous to clk; everything downstream sees only rows_s
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= row_in;
            rows_s <= rows_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick        = (div_cnt == DIV_LAST);
    assign col_rot     = {col_out[2:0], col_out[3]};
    assign cap_pattern = ~(4'b0001 << cap_row);

    always_comb begin
        one_low = 1'b1;
        row_idx = 2'd0;
        case (rows_s)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    always_comb begin
        case (col_out)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SCAN;
            cnt      <= '0;
            cap_row  <= 2'd0;
            cap_col  <= 2'd0;
            col_out  <= 4'b1110;
            data_out <= 4'd0;
            flag     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cap_row  <= cap_row_n;
            cap_col  <= cap_col_n;
            col_out  <= col_n;
            data_out <= data_n;
            flag     <= flag_n;
        end
    end

    // Only tick cycles move the FSM; flag_n defaults low so the strobe self-clears
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cap_row_n = cap_row;
        cap_col_n = cap_col;
        col_n     = col_out;
        data_n    = data_out;
        flag_n    = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (one_low) begin
                        cap_row_n = row_idx;
                        cap_col_n = col_idx;
                        cnt_n     = '0;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_n = col_rot;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == cap_pattern) begin
                        if (cnt == CNT_LAST) begin
                            data_n  = key_code(cap_row, cap_col);
                            flag_n  = 1'b1;
                            state_n = PRESSED;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else begin
                        state_n = SCAN;
                        col_n   = col_rot;
                    end
                end
                PRESSED: begin
                    if (rows_s == 4'hF) begin
                        cnt_n   = '0;
                        state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rows_s == 4'hF) begin
                        if (cnt == CNT_LAST)
                            state_n = SCAN;
                        else
                            cnt_n = cnt + 1'b1;
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: key-matrix model drives rows from the DUT columns,
// and each clean press is expected to yield exactly one flag with its mapped code.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] data_out;
    logic       flag;

    int checks = 0;
    int errors = 0;

    bit [15:0] held = '0;
    int        keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 15, 0, 14, 13};
    int        got[$];
    int        exp[$];
    bit        prev_flag = 1'b0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .data_out(data_out),
        .flag    (flag)
    );

    always #5 clk = ~clk;

    // A held key shorts its row to its column when that column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !col_out[c])
                    row_in[r] = 1'b0;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setKey(input int r, input int c, input bit down);
        held[r*4+c] = down;
    endtask

    // Press a key, hold it, release it and wait out the release debounce
    task automatic applyStimulus(input int r, input int c, input int hold, input int gap);
        setKey(r, c, 1'b1);
        exp.push_back(keymap[r*4+c]);
        waitCycles(hold);
        setKey(r, c, 1'b0);
        waitCycles(gap);
    endtask

    task automatic scoreboard(input string tag);
        checkOutput({tag, " flag count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            checkOutput($sformatf("%s code %0d", tag, i), got[i], exp[i]);
        got.delete();
        exp.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_flag = 1'b0;
        end else begin
            if (flag) begin
                got.push_back(int'(data_out));
                checkOutput("flag single cycle", int'(prev_flag), 0);
            end
            prev_flag = flag;
        end
    end

    initial begin
        int r, c, k;

        rst = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(6);

        // reset mid-count
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("reset col_out", int'(col_out), 4'b1110);
        checkOutput("reset data_out", int'(data_out), 0);
        checkOutput("reset flag", int'(flag), 0);
        waitCycles(3);
        checkOutput("col before first tick", int'(col_out), 4'b1110);
        waitCycles(1);
        checkOutput("col after first tick", int'(col_out), 4'b1101);
        waitCycles(4);

        // clean press of key 6
        applyStimulus(1, 2, 40, 40);
        scoreboard("clean press");
        checkOutput("data holds after release", int'(data_out), 6);

        // bouncy press of key 1: 3 low / 3 high never gives 4 consecutive low ticks
        for (int i = 0; i < 4; i++) begin
            setKey(0, 0, 1'b1);
            waitCycles(3);
            setKey(0, 0, 1'b0);
            waitCycles(3);
        end
        checkOutput("bounce no flag", got.size(), 0);
        applyStimulus(0, 0, 40, 40);
        scoreboard("bouncy press");

        // long hold of key 14, then a release bounce
        setKey(3, 2, 1'b1);
        exp.push_back(14);
        waitCycles(200);
        scoreboard("long hold");
        setKey(3, 2, 1'b0);
        waitCycles(8);
        setKey(3, 2, 1'b1);
        waitCycles(4);
        setKey(3, 2, 1'b0);
        waitCycles(10);
        checkOutput("release bounce column held", int'(col_out), 4'b1011);
        checkOutput("release bounce no flag", got.size(), 0);
        waitCycles(30);
        checkOutput("release bounce data holds", int'(data_out), 14);

        // two keys in column 3: multi-key ignored until one is released
        setKey(0, 3, 1'b1);
        setKey(1, 3, 1'b1);
        waitCycles(60);
        checkOutput("two keys no flag", got.size(), 0);
        setKey(1, 3, 1'b0);
        exp.push_back(10);
        waitCycles(40);
        setKey(0, 3, 1'b0);
        waitCycles(40);
        scoreboard("two keys");

        // sequence 1, 2, 10, 3, 14
        applyStimulus(0, 0, 40, 40);
        applyStimulus(0, 1, 40, 40);
        applyStimulus(0, 3, 40, 40);
        applyStimulus(0, 2, 40, 40);
        applyStimulus(3, 2, 40, 40);
        scoreboard("sequence");

        // key held through a reset is re-detected as a new press
        setKey(2, 1, 1'b1);
        exp.push_back(8);
        waitCycles(40);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("reset mid-press data_out", int'(data_out), 0);
        exp.push_back(8);
        waitCycles(50);
        setKey(2, 1, 1'b0);
        waitCycles(40);
        scoreboard("held through reset");

        // random keys with random hold and gap lengths
        for (int i = 0; i < 10; i++) begin
            k = int'($urandom_range(15));
            r = k / 4;
            c = k % 4;
            applyStimulus(r, c, 45 + int'($urandom_range(30)), 40 + int'($urandom_range(20)));
            checkOutput($sformatf("random data_out %0d", i), int'(data_out), keymap[k]);
        end
        scoreboard("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
